bus_sram_responder: RTL and testbench
=====================================

// Module: bus_sram_responder
// PURPOSE
//  Data-bus responder at the far end of the core's REQ/GNT load/store interface: word-organised
//  synchronous SRAM with programmable wait states, byte/half/word lanes and error reporting.
//  Sole data slave on the core data bus; decodes its own address window and completes every request.
// PARAMETERS
//  DEPTH_WORDS  1024          number of 32-bit words (power of 2, >=2)
//  BASE_ADDR    32'h0000_1000 byte address of word 0 (aligned to DEPTH_WORDS*4)
//  WAIT_STATES  1             extra cycles before GNT (0..15)
// PORTS
//  i_CLK        in   1   clock, rising edge
//  i_RSTn       in   1   reset, asynchronous, active-low
//  i_BUS_REQ    in   1   initiator request; ADDR/WDATA/WE/RE/HB stable while high until GNT
//  i_BUS_ADDR   in   32  byte address
//  i_BUS_WDATA  in   32  write data, right-justified (byte in [7:0], half in [15:0])
//  i_BUS_WE     in   1   write access
//  i_BUS_RE     in   1   read access
//  i_BUS_HB     in   2   size: 00 byte, 01 half, 10 word, 11 reserved
//  o_BUS_GNT    out  1   one-cycle completion strobe
//  o_BUS_RDATA  out  32  read data, right-justified, zero-extended; valid only while GNT=1
//  o_BUS_ERR    out  1   error flag, valid only while GNT=1
// BEHAVIOUR
//  Reset: o_BUS_GNT=0, o_BUS_ERR=0, o_BUS_RDATA=0, FSM=IDLE, wait counter=0. Array not reset.
//  FSM IDLE -> (REQ=1) WAIT (WAIT_STATES>0, counter loaded WAIT_STATES-1) or RESP (WAIT_STATES=0).
//   WAIT: counter decrements per cycle; at 0 -> RESP. REQ=0 in WAIT (protocol violation)
//   -> IDLE, no write, no GNT.
//   RESP: GNT=1 for exactly one cycle; next state IDLE unconditionally (REQ ignored in this cycle).
//  Latency: REQ sampled high at edge k -> GNT high in cycle after edge k+WAIT_STATES.
//   Back-to-back: new REQ sampled first in IDLE cycle after RESP; min period WAIT_STATES+2 cycles.
//  Commit: write and read-data/ERR registers update on the edge entering RESP, from inputs then.
//  Error (ERR=1, no array write, RDATA=0): address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS);
//   HB=11; half with ADDR[0]=1; word with ADDR[1:0]!=0; WE=RE=1; WE=RE=0.
//  Index = (ADDR-BASE_ADDR)>>2. Lane = ADDR[1:0] (byte) or ADDR[1] (half).
//  Write: only addressed byte lanes updated via per-byte enables; other bytes unchanged.
//  Read: selected lane shifted to bit 0, upper bits zero; initiator does sign extension.
//  Read of a word written in the previous transaction returns new data (no forwarding hazard, commit
//   precedes next IDLE sample).
//  Reset asserted mid-WAIT/RESP: immediate IDLE, GNT/ERR/RDATA cleared; an uncommitted write is
//   dropped, a write committed on the RESP-entry edge stands.
//  GNT/ERR/RDATA outputs are registered; no combinational path from any input to any output.
// TESTING
//  Reset then WAIT_STATES=1: SW 0xDEADBEEF @0x1000, REQ held -> GNT 2 cycles after REQ sample, ERR=0;
//   LW @0x1000 -> RDATA=0xDEADBEEF.
//  SB 0xAA @0x1002 over 0x11223344 -> LW returns 0x11AA3344; LB @0x1002 -> 0x000000AA;
//   LH @0x1002 -> 0x000011AA.
//  Misaligned LH @0x1001, LW @0x1006, HB=11, addr 0x0FFC, addr BASE+4*DEPTH -> GNT with ERR=1,
//   RDATA=0, memory unchanged.
//  WAIT_STATES=0 back-to-back SW/LW stream of 16 accesses -> GNT every 2nd cycle, data matches
//   reference model.
//  REQ dropped during WAIT, then new LW -> no GNT for aborted access, no write, LW completes
//   normally.
//  i_RSTn pulsed low while in RESP -> GNT/ERR/RDATA low asynchronously; subsequent access
//   completes with normal latency.

Source files
------------

// File: rtl/bus_sram_responder.sv
// ---------------------------------------------------------------------------
// bus_sram_responder
//   Data-bus responder for the core REQ/GNT load/store interface. It holds a
//   word-organised SRAM behind a programmable number of wait states, supports
//   byte, half and word accesses, and flags every access it cannot complete.
//   Every request is answered with a one-cycle GNT pulse. A request dropped
//   while waiting is abandoned: there is no GNT and no write.
//
// Ports
//   i_CLK        clock, rising edge
//   i_RSTn       asynchronous active-low reset
//   i_BUS_REQ    request; address/data/controls are held stable until GNT
//   i_BUS_ADDR   byte address
//   i_BUS_WDATA  right-justified write data
//   i_BUS_WE     write access
//   i_BUS_RE     read access
//   i_BUS_HB     size: 00 byte, 01 half, 10 word, 11 reserved
//   o_BUS_GNT    one-cycle completion strobe (registered)
//   o_BUS_RDATA  right-justified, zero-extended read data (registered)
//   o_BUS_ERR    error flag, meaningful only with GNT (registered)
// ---------------------------------------------------------------------------
module bus_sram_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic        i_BUS_REQ,
    input  logic [31:0] i_BUS_ADDR,
    input  logic [31:0] i_BUS_WDATA,
    input  logic        i_BUS_WE,
    input  logic        i_BUS_RE,
    input  logic [1:0]  i_BUS_HB,
    output logic        o_BUS_GNT,
    output logic [31:0] o_BUS_RDATA,
    output logic        o_BUS_ERR
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
    localparam logic        HAS_WAIT = (WAIT_STATES != 0);
    localparam logic [3:0]  WS_LOAD  = (WAIT_STATES != 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_q, gnt_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0]      offset_s;
    logic             in_range_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      rd_word_s;
    logic             dec_err_s;
    logic [3:0]       be_s;
    logic [31:0]      wlane_s;
    logic [31:0]      rlane_s;
    logic             commit_s;
    logic             mem_we_s;

    // The subtraction wraps below BASE_ADDR, so a single unsigned compare covers both window edges.
    assign offset_s   = i_BUS_ADDR - BASE_ADDR;
    assign in_range_s = (offset_s < SPAN);
    assign idx_s      = offset_s[IDX_W+1:2];
    assign rd_word_s  = mem[idx_s];

    // Access decode: error detection, write byte enables and the replicated write lanes, read lane extraction.
    always_comb begin
        dec_err_s = 1'b0;
        be_s      = 4'b0000;
        wlane_s   = i_BUS_WDATA;
        rlane_s   = 32'd0;
        case (i_BUS_HB)
            2'b00: begin
                be_s    = 4'b0001 << i_BUS_ADDR[1:0];
                wlane_s = {4{i_BUS_WDATA[7:0]}};
                case (i_BUS_ADDR[1:0])
                    2'd0:    rlane_s = {24'd0, rd_word_s[7:0]};
                    2'd1:    rlane_s = {24'd0, rd_word_s[15:8]};
                    2'd2:    rlane_s = {24'd0, rd_word_s[23:16]};
                    2'd3:    rlane_s = {24'd0, rd_word_s[31:24]};
                    default: rlane_s = 32'd0;
                endcase
            end
            2'b01: begin
                wlane_s = {2{i_BUS_WDATA[15:0]}};
                if (i_BUS_ADDR[0]) begin
                    dec_err_s = 1'b1;
                end else if (i_BUS_ADDR[1]) begin
                    be_s    = 4'b1100;
                    rlane_s = {16'd0, rd_word_s[31:16]};
                end else begin
                    be_s    = 4'b0011;
                    rlane_s = {16'd0, rd_word_s[15:0]};
                end
            end
            2'b10: begin
                be_s    = 4'b1111;
                rlane_s = rd_word_s;
                if (i_BUS_ADDR[1:0] != 2'b00) begin
                    dec_err_s = 1'b1;
                end else begin
                    dec_err_s = 1'b0;
                end
            end
            default: begin
                dec_err_s = 1'b1;
            end
        endcase
        // Out-of-window and ambiguous (both or neither of WE/RE) accesses are rejected whatever the size.
        if (!in_range_s || (i_BUS_WE == i_BUS_RE)) begin
            dec_err_s = 1'b1;
        end else begin
            dec_err_s = dec_err_s;
        end
    end

    // Handshake FSM: IDLE -> [WAIT] -> RESP -> IDLE. The edge that enters RESP commits the access.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_BUS_REQ && HAS_WAIT) begin
                    state_d = ST_WAIT;
                    cnt_d   = WS_LOAD;
                end else if (i_BUS_REQ) begin
                    state_d  = ST_RESP;
                    commit_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!i_BUS_REQ) begin
                    // The initiator withdrew: abandon quietly.
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d  = ST_RESP;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // REQ is deliberately ignored here; the next request is sampled in IDLE.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Response register contents: GNT only in RESP; read data and error are zero outside RESP.
    always_comb begin
        gnt_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'd0;
        if (commit_s) begin
            gnt_d = 1'b1;
            err_d = dec_err_s;
            if (!dec_err_s && i_BUS_RE) begin
                rdata_d = rlane_s;
            end else begin
                rdata_d = 32'd0;
            end
        end else begin
            gnt_d = 1'b0;
        end
    end

    // While reset is held the FSM sits in IDLE, so the write must also be blocked explicitly.
    assign mem_we_s = commit_s && !dec_err_s && i_BUS_WE && i_RSTn;

    // Control and response registers.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            gnt_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // SRAM array with per-byte write enables. Its contents are not reset.
    always_ff @(posedge i_CLK) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem[idx_s][8*b +: 8] <= wlane_s[8*b +: 8];
                end
            end
        end
    end

    assign o_BUS_GNT   = gnt_q;
    assign o_BUS_ERR   = err_q;
    assign o_BUS_RDATA = rdata_q;

endmodule

// File: tb/tb_bus_sram_responder.sv
module tb_bus_sram_responder;

    logic        clk;
    logic        rst_n;
    logic        req1, req0;
    logic [31:0] addr, wdata;
    logic        we, re;
    logic [1:0]  hb;
    logic        gnt1, gnt0, err1, err0;
    logic [31:0] rdata1, rdata0;

    int n_vec  = 0;
    int n_miss = 0;

    // Wait-state DUT (WAIT_STATES=1)
    bus_sram_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(1)) u_dut1 (
        .i_CLK(clk), .i_RSTn(rst_n), .i_BUS_REQ(req1), .i_BUS_ADDR(addr), .i_BUS_WDATA(wdata),
        .i_BUS_WE(we), .i_BUS_RE(re), .i_BUS_HB(hb),
        .o_BUS_GNT(gnt1), .o_BUS_RDATA(rdata1), .o_BUS_ERR(err1)
    );

    // Zero-wait DUT (WAIT_STATES=0)
    bus_sram_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) u_dut0 (
        .i_CLK(clk), .i_RSTn(rst_n), .i_BUS_REQ(req0), .i_BUS_ADDR(addr), .i_BUS_WDATA(wdata),
        .i_BUS_WE(we), .i_BUS_RE(re), .i_BUS_HB(hb),
        .o_BUS_GNT(gnt0), .o_BUS_RDATA(rdata0), .o_BUS_ERR(err0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one access on the selected DUT and wait for GNT; REQ stays high on return.
    task automatic acc(input bit sel, input logic w, input logic r, input logic [1:0] h,
                       input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                       output logic [31:0] rd, output logic e);
        int n;
        addr = a; wdata = d; we = w; re = r; hb = h;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        n  = 0;
        rd = 32'hxxxx_xxxx;
        e  = 1'bx;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n++;
            if ((sel ? gnt1 : gnt0) === 1'b1) begin
                rd = sel ? rdata1 : rdata0;
                e  = sel ? err1 : err0;
                break;
            end
        end
        check_val($sformatf("latency@%h", a), 32'(n), 32'(exp_lat));
    endtask

    // Release REQ and let the RESP cycle retire; GNT must already be gone.
    task automatic idle_cycle(input bit sel);
        req1 = 1'b0;
        req0 = 1'b0;
        @(posedge clk);
        #1;
        check_val("gnt_pulse", {31'd0, sel ? gnt1 : gnt0}, 32'd0);
    endtask

    // Standalone access on the wait-state DUT, with data and error checks.
    task automatic op1(input string tag, input logic w, input logic r, input logic [1:0] h,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        e;
        acc(1'b1, w, r, h, a, d, 2, rd, e);
        check_val({tag, "_rdata"}, rd, exp_rd);
        check_val({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
        idle_cycle(1'b1);
    endtask

    logic [31:0] model [8];
    logic [31:0] rd_v;
    logic        e_v;

    initial begin
        rst_n = 1'b0;
        req1 = 1'b0; req0 = 1'b0;
        addr = 32'd0; wdata = 32'd0; we = 1'b0; re = 1'b0; hb = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_gnt", {31'd0, gnt1}, 32'd0);
        check_val("rst_err", {31'd0, err1}, 32'd0);
        check_val("rst_rdata", rdata1, 32'd0);
        check_val("rst_gnt0", {31'd0, gnt0}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic word write/read with one wait state
        op1("sw_dead", 1'b1, 1'b0, 2'b10, 32'h1000, 32'hDEAD_BEEF, 32'd0, 1'b0);
        op1("lw_dead", 1'b0, 1'b1, 2'b10, 32'h1000, 32'd0, 32'hDEAD_BEEF, 1'b0);

        // Byte and half lanes
        op1("sw_1122", 1'b1, 1'b0, 2'b10, 32'h1000, 32'h1122_3344, 32'd0, 1'b0);
        op1("sb_aa", 1'b1, 1'b0, 2'b00, 32'h1002, 32'h0000_00AA, 32'd0, 1'b0);
        op1("lw_merge", 1'b0, 1'b1, 2'b10, 32'h1000, 32'd0, 32'h11AA_3344, 1'b0);
        op1("lb_1002", 1'b0, 1'b1, 2'b00, 32'h1002, 32'd0, 32'h0000_00AA, 1'b0);
        op1("lh_1002", 1'b0, 1'b1, 2'b01, 32'h1002, 32'd0, 32'h0000_11AA, 1'b0);
        op1("lb_1001", 1'b0, 1'b1, 2'b00, 32'h1001, 32'd0, 32'h0000_0033, 1'b0);
        op1("lh_1000", 1'b0, 1'b1, 2'b01, 32'h1000, 32'd0, 32'h0000_3344, 1'b0);
        op1("sh_1006", 1'b1, 1'b0, 2'b01, 32'h1006, 32'h0000_0BAD, 32'd0, 1'b0);
        op1("sh_1004", 1'b1, 1'b0, 2'b01, 32'h1004, 32'h0000_F00D, 32'd0, 1'b0);
        op1("lw_1004", 1'b0, 1'b1, 2'b10, 32'h1004, 32'd0, 32'h0BAD_F00D, 1'b0);

        // Error cases: all must be flagged, return zero and leave memory alone
        op1("e_lh_mis", 1'b0, 1'b1, 2'b01, 32'h1001, 32'd0, 32'd0, 1'b1);
        op1("e_sh_mis", 1'b1, 1'b0, 2'b01, 32'h1001, 32'h0000_FFFF, 32'd0, 1'b1);
        op1("e_lw_mis", 1'b0, 1'b1, 2'b10, 32'h1006, 32'd0, 32'd0, 1'b1);
        op1("e_sw_mis", 1'b1, 1'b0, 2'b10, 32'h1006, 32'h5555_5555, 32'd0, 1'b1);
        op1("e_hb11_r", 1'b0, 1'b1, 2'b11, 32'h1000, 32'd0, 32'd0, 1'b1);
        op1("e_hb11_w", 1'b1, 1'b0, 2'b11, 32'h1004, 32'h5555_5555, 32'd0, 1'b1);
        op1("e_lo", 1'b0, 1'b1, 2'b10, 32'h0FFC, 32'd0, 32'd0, 1'b1);
        op1("e_hi", 1'b0, 1'b1, 2'b10, 32'h2000, 32'd0, 32'd0, 1'b1);
        op1("e_wr_hi", 1'b1, 1'b0, 2'b10, 32'h2000, 32'h5555_5555, 32'd0, 1'b1);
        op1("e_wer", 1'b1, 1'b1, 2'b10, 32'h1004, 32'h5555_5555, 32'd0, 1'b1);
        op1("e_none", 1'b0, 1'b0, 2'b10, 32'h1000, 32'h5555_5555, 32'd0, 1'b1);
        op1("keep_1000", 1'b0, 1'b1, 2'b10, 32'h1000, 32'd0, 32'h11AA_3344, 1'b0);
        op1("keep_1004", 1'b0, 1'b1, 2'b10, 32'h1004, 32'd0, 32'h0BAD_F00D, 1'b0);

        // Request withdrawn during WAIT: no GNT and no write
        op1("sw_1010", 1'b1, 1'b0, 2'b10, 32'h1010, 32'h1234_5678, 32'd0, 1'b0);
        addr = 32'h1010; wdata = 32'h5555_5555; we = 1'b1; re = 1'b0; hb = 2'b10;
        req1 = 1'b1;
        @(posedge clk);
        #1;
        check_val("abort_gnt_a", {31'd0, gnt1}, 32'd0);
        req1 = 1'b0;
        @(posedge clk);
        #1;
        check_val("abort_gnt_b", {31'd0, gnt1}, 32'd0);
        @(posedge clk);
        #1;
        check_val("abort_gnt_c", {31'd0, gnt1}, 32'd0);
        op1("lw_1010", 1'b0, 1'b1, 2'b10, 32'h1010, 32'd0, 32'h1234_5678, 1'b0);

        // Reset pulse while a read is in RESP clears the outputs immediately
        acc(1'b1, 1'b0, 1'b1, 2'b10, 32'h1000, 32'd0, 2, rd_v, e_v);
        check_val("pre_rst_rdata", rd_v, 32'h11AA_3344);
        req1 = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("arst_gnt", {31'd0, gnt1}, 32'd0);
        check_val("arst_rdata", rdata1, 32'd0);
        check_val("arst_err", {31'd0, err1}, 32'd0);
        #1;
        rst_n = 1'b1;

        // A write committed on the RESP-entry edge survives a reset pulse in RESP
        acc(1'b1, 1'b1, 1'b0, 2'b10, 32'h1020, 32'hCAFE_F00D, 2, rd_v, e_v);
        check_val("sw_1020_err", {31'd0, e_v}, 32'd0);
        req1 = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("arst2_gnt", {31'd0, gnt1}, 32'd0);
        #1;
        rst_n = 1'b1;
        op1("lw_1020", 1'b0, 1'b1, 2'b10, 32'h1020, 32'd0, 32'hCAFE_F00D, 1'b0);

        // Zero-wait back-to-back stream: store slot j, then load slot j/2
        for (int i = 0; i < 16; i++) begin
            int j;
            logic [31:0] d;
            j = i / 2;
            if ((i % 2) == 0) begin
                d = 32'h1357_9BDF + 32'(j) * 32'h0102_0304;
                model[j] = d;
                acc(1'b0, 1'b1, 1'b0, 2'b10, 32'h1000 + 32'(4 * j), d, (i == 0) ? 1 : 2, rd_v, e_v);
                check_val($sformatf("s0_sw%0d_err", j), {31'd0, e_v}, 32'd0);
            end else begin
                acc(1'b0, 1'b0, 1'b1, 2'b10, 32'h1000 + 32'(4 * (j / 2)), 32'd0, 2, rd_v, e_v);
                check_val($sformatf("s0_lw%0d", j / 2), rd_v, model[j / 2]);
            end
        end
        idle_cycle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
